// File: rtl/db15_shift_reader_pkg.sv
// Shared types and constants for the DB15 serial front end: FSM states, button bit positions, frame size.
// Pure declarations; no latency and no backpressure.
package db15_pkg;

   localparam int NUM_PLAYERS     = 2;
   localparam int BITS_PER_PLAYER = 12;
   localparam int FRAME_BITS      = NUM_PLAYERS * BITS_PER_PLAYER;

   // Per-player word layout, LSB first: R L D U A B C D E F S L
   localparam int BTN_R  = 0;
   localparam int BTN_LT = 1;
   localparam int BTN_DN = 2;
   localparam int BTN_UP = 3;
   localparam int BTN_A  = 4;
   localparam int BTN_B  = 5;
   localparam int BTN_C  = 6;
   localparam int BTN_D  = 7;
   localparam int BTN_E  = 8;
   localparam int BTN_F  = 9;
   localparam int BTN_S  = 10;
   localparam int BTN_L  = 11;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      SHIFT_LO,
      SHIFT_HI,
      UPDATE
   } state_t;

   function automatic logic [15:0] to_joy(input logic [BITS_PER_PLAYER-1:0] b);
      return {{(16 - BITS_PER_PLAYER){1'b0}}, b};
   endfunction

endpackage

// File: rtl/db15_shift_reader_tick_gen.sv
// Free-running divider: one-clk tick strobe every CLK_DIV clocks (CLK_DIV >= 2), held at count 0 in reset.
// Tick is decoded from the registered count; no backpressure.
module db15_tick_gen #(
   parameter int CLK_DIV = 48
) (
   input  logic clk_i,
   input  logic rst_ni,
   output logic tick_o
);

   localparam int CW = $clog2(CLK_DIV);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   assign tick_o = (cnt_q == CW'(CLK_DIV - 1));
   assign cnt_d  = tick_o ? '0 : cnt_q + CW'(1);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/db15_shift_reader.sv
// DB15 adapter front end: drives the 74HC165 load/clock chain and deserialises two 12-bit player words.
// Both words update together one clk after the last bit; no backpressure. DB15_DEBOUNCE_EN publishes only on two equal frames.
module db15_shift_reader
   import db15_pkg::*;
#(
   parameter int CLK_DIV   = 48,
   parameter int GAP_TICKS = 16
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        joy_data,
   output logic        joy_clk,
   output logic        joy_load,
   output logic [15:0] joystick1,
   output logic [15:0] joystick2,
   output logic        frame_done
);

   localparam int GW = $clog2(GAP_TICKS + 2);
   localparam int BW = $clog2(FRAME_BITS);

   logic                  rst_meta_q, rst_sync_q;
   logic                  data_meta_q, data_sync_q;
   logic                  tick;
   state_t                state_q;
   logic [GW-1:0]         gap_q;
   logic [BW-1:0]         bit_q;
   logic [FRAME_BITS-1:0] sr_q;
   logic                  joy_clk_q, joy_load_q, frame_done_q;
   logic [15:0]           joystick1_q, joystick2_q;
`ifdef DB15_DEBOUNCE_EN
   logic [FRAME_BITS-1:0] cand_q;
`endif

   // Reset asserts immediately but leaves synchronously to clk
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rst_meta_q <= 1'b0;
         rst_sync_q <= 1'b0;
      end else begin
         rst_meta_q <= 1'b1;
         rst_sync_q <= rst_meta_q;
      end
   end

   always_ff @(posedge clk or negedge rst_sync_q) begin
      if (!rst_sync_q) begin
         data_meta_q <= 1'b1;
         data_sync_q <= 1'b1;
      end else begin
         data_meta_q <= joy_data;
         data_sync_q <= data_meta_q;
      end
   end

   db15_tick_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_tick (
      .clk_i  (clk),
      .rst_ni (rst_sync_q),
      .tick_o (tick)
   );

   always_ff @(posedge clk or negedge rst_sync_q) begin
      if (!rst_sync_q) begin
         state_q      <= IDLE;
         gap_q        <= '0;
         bit_q        <= '0;
         sr_q         <= '0;
         joy_clk_q    <= 1'b0;
         joy_load_q   <= 1'b1;
         joystick1_q  <= '0;
         joystick2_q  <= '0;
         frame_done_q <= 1'b0;
`ifdef DB15_DEBOUNCE_EN
         cand_q       <= '0;
`endif
      end else begin
         frame_done_q <= 1'b0;
         unique case (state_q)
            IDLE: if (tick) begin
               if (gap_q == GW'(GAP_TICKS)) begin
                  joy_load_q <= 1'b0;
                  state_q    <= LOAD;
               end else begin
                  gap_q <= gap_q + GW'(1);
               end
            end
            LOAD: if (tick) begin
               joy_load_q <= 1'b1;
               bit_q      <= '0;
               state_q    <= SHIFT_LO;
            end
            // Data line is active-low; the bit is taken just before the rising joy_clk
            SHIFT_LO: if (tick) begin
               sr_q[bit_q] <= ~data_sync_q;
               joy_clk_q   <= 1'b1;
               state_q     <= SHIFT_HI;
            end
            SHIFT_HI: if (tick) begin
               joy_clk_q <= 1'b0;
               if (bit_q == BW'(FRAME_BITS - 1)) begin
                  state_q <= UPDATE;
               end else begin
                  bit_q   <= bit_q + BW'(1);
                  state_q <= SHIFT_LO;
               end
            end
            UPDATE: begin
`ifdef DB15_DEBOUNCE_EN
               cand_q <= sr_q;
               if (sr_q == cand_q) begin
                  joystick1_q  <= to_joy(sr_q[BITS_PER_PLAYER-1:0]);
                  joystick2_q  <= to_joy(sr_q[FRAME_BITS-1:BITS_PER_PLAYER]);
                  frame_done_q <= 1'b1;
               end
`else
               joystick1_q  <= to_joy(sr_q[BITS_PER_PLAYER-1:0]);
               joystick2_q  <= to_joy(sr_q[FRAME_BITS-1:BITS_PER_PLAYER]);
               frame_done_q <= 1'b1;
`endif
               gap_q   <= '0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign joy_clk    = joy_clk_q;
   assign joy_load   = joy_load_q;
   assign joystick1  = joystick1_q;
   assign joystick2  = joystick2_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_db15_shift_reader.sv
// Bench for db15_shift_reader: 74HC165 chain models feed a default instance and a fast (CLK_DIV=2, no gap) one.
// A frame-level reference model predicts published words and frame_done counts at every LOAD edge.
module tb_db15_shift_reader;
   import db15_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst0_n = 1'b0, rst1_n = 1'b0;
   logic        jd0 = 1'b1, jd1 = 1'b1;
   logic        jclk0, jload0, fd0, jclk1, jload1, fd1;
   logic [15:0] j1_0, j2_0, j1_1, j2_1;
   logic [23:0] btn0 = '0, btn1 = '0;
   logic [23:0] snap0 = '0, snap1 = '0;
   int          idx0 = 0, idx1 = 0;

   int n_pass = 0, n_fail = 0, n_tot = 0;
   int fd_cnt0 = 0, fd_run0 = 0, fd_maxrun0 = 0, jr_cnt0 = 0;

   bit          have_prev = 1'b0;
   logic [23:0] prev_m = '0, cand_m = '0, exp_m = '0;
   int          fd_base = 0, jr_base = 0;

   db15_shift_reader u0 (
      .clk(clk), .reset_n(rst0_n), .joy_data(jd0), .joy_clk(jclk0), .joy_load(jload0),
      .joystick1(j1_0), .joystick2(j2_0), .frame_done(fd0)
   );

   db15_shift_reader #(.CLK_DIV(2), .GAP_TICKS(0)) u1 (
      .clk(clk), .reset_n(rst1_n), .joy_data(jd1), .joy_clk(jclk1), .joy_load(jload1),
      .joystick1(j1_1), .joystick2(j2_1), .frame_done(fd1)
   );

   // Adapter: parallel capture while load is low, one bit per rising joy_clk, released buttons read high
   always @(negedge jload0 or posedge jclk0) begin
      if (!jload0) begin snap0 = btn0; idx0 = 0; end
      else idx0 = idx0 + 1;
      jd0 = (idx0 < 24) ? ~snap0[idx0[4:0]] : 1'b1;
   end

   always @(negedge jload1 or posedge jclk1) begin
      if (!jload1) begin snap1 = btn1; idx1 = 0; end
      else idx1 = idx1 + 1;
      jd1 = (idx1 < 24) ? ~snap1[idx1[4:0]] : 1'b1;
   end

   always @(negedge clk) begin
      if (fd0) begin
         fd_cnt0 = fd_cnt0 + 1;
         fd_run0 = fd_run0 + 1;
         if (fd_run0 > fd_maxrun0) fd_maxrun0 = fd_run0;
      end else begin
         fd_run0 = 0;
      end
   end

   always @(posedge jclk0) jr_cnt0 = jr_cnt0 + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tot++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_load(input int inst, input int budget, output int cyc, output bit ok);
      logic last, cur;
      last = (inst == 0) ? jload0 : jload1;
      ok = 1'b0;
      cyc = 0;
      for (int i = 0; i < budget; i++) begin
         @(posedge clk); #1;
         cyc++;
         cur = (inst == 0) ? jload0 : jload1;
         if (last && !cur) begin ok = 1'b1; break; end
         last = cur;
      end
   endtask

   task automatic wait_load_high(input int inst, output int cyc);
      cyc = 0;
      for (int i = 0; i < 200; i++) begin
         @(posedge clk); #1;
         cyc++;
         if (((inst == 0) ? jload0 : jload1) == 1'b1) break;
      end
   endtask

   task automatic wait_rises(input int n, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 4000; i++) begin
         @(posedge clk); #1;
         if (jr_cnt0 - jr_base >= n) begin ok = 1'b1; break; end
      end
   endtask

   // Called just after a LOAD fall: the previous frame is complete, the new snapshot is taken
   task automatic frame_eval(input string tag);
      bit pub;
      pub = 1'b0;
      if (have_prev) begin
`ifdef DB15_DEBOUNCE_EN
         pub = (prev_m == cand_m);
         cand_m = prev_m;
`else
         pub = 1'b1;
`endif
         if (pub) exp_m = prev_m;
         check({tag, "_clk_rises"}, jr_cnt0 - jr_base, FRAME_BITS);
      end
      check({tag, "_p1"}, j1_0, {4'h0, exp_m[11:0]});
      check({tag, "_p2"}, j2_0, {4'h0, exp_m[23:12]});
      check({tag, "_fd_count"}, fd_cnt0 - fd_base, pub ? 1 : 0);
      if (pub) check({tag, "_fd_width"}, fd_maxrun0, 1);
      prev_m    = snap0;
      have_prev = 1'b1;
      fd_base   = fd_cnt0;
      jr_base   = jr_cnt0;
   endtask

   task automatic frame_step(input string tag);
      int cyc;
      bit ok;
      wait_load(0, 4000, cyc, ok);
      check({tag, "_load_seen"}, ok, 1'b1);
      frame_eval(tag);
   endtask

   initial begin
      int cyc;
      bit ok, ok_all;
      logic [23:0] base;

      repeat (3) @(posedge clk);
      #1;
      check("rst_load", jload0, 1'b1);
      check("rst_jclk", jclk0, 1'b0);
      check("rst_p1", j1_0, 16'h0000);
      check("rst_p2", j2_0, 16'h0000);
      check("rst_fd", fd0, 1'b0);

      // Fast instance: first tick enters LOAD, alternating patterns over all 24 bits
      btn1 = 24'hAAAAAA;
      @(negedge clk); rst1_n = 1'b1;
      wait_load(1, 50, cyc, ok);
      check("fast_first_load", cyc, 2 + 2 * 1);
      wait_load_high(1, cyc);
      check("fast_load_width", cyc, 2);
      ok_all = 1'b1;
      repeat (4) begin wait_load(1, 300, cyc, ok); ok_all &= ok; end
      check("fast_aaa_p1", j1_1, 16'h0AAA);
      check("fast_aaa_p2", j2_1, 16'h0AAA);
      btn1 = 24'h555555;
      repeat (4) begin wait_load(1, 300, cyc, ok); ok_all &= ok; end
      check("fast_555_p1", j1_1, 16'h0555);
      check("fast_555_p2", j2_1, 16'h0555);
      check("fast_loads_seen", ok_all, 1'b1);

      // Default instance: all buttons released
      @(negedge clk); rst0_n = 1'b1;
      wait_load(0, 2000, cyc, ok);
      check("first_load_cycle", cyc, 2 + 48 * 17);
      frame_eval("f0");
      wait_load_high(0, cyc);
      check("load_width", cyc, 48);
      frame_step("idle");

      base = 24'h0;
      base[BTN_R] = 1'b1;
      base[BTN_A] = 1'b1;
      base[12 + BTN_S] = 1'b1;
      base[12 + BTN_UP] = 1'b1;
      btn0 = base;
      frame_step("press_a");
      frame_step("press_b");
      frame_step("press_c");
      check("press_p1_direct", j1_0, 16'h0011);
      check("press_p2_direct", j2_0, 16'h0408);

      btn0 = base | (24'h1 << BTN_DN);
      frame_step("glitch_a");
      btn0 = base;
      frame_step("glitch_b");
      frame_step("glitch_c");

      for (int i = 0; i < 2; i++) begin
         btn0 = 24'($urandom());
         frame_step("rand_a");
         frame_step("rand_b");
      end

      // Change after bit 5 has been shifted: the frame keeps the LOAD-time snapshot
      btn0 = 24'h0F0F0F;
      frame_step("mid_a");
      frame_step("mid_b");
      wait_rises(6, ok);
      check("mid_rises_seen", ok, 1'b1);
      btn0 = 24'hF0F0F0;
      frame_step("mid_c");
      check("mid_old_p1", j1_0, 16'h0F0F);
      check("mid_old_p2", j2_0, 16'h00F0);
      frame_step("mid_d");

      // Reset while the 14th bit is in its high phase
      wait_rises(14, ok);
      check("rst_rises_seen", ok, 1'b1);
      check("pre_rst_nonzero", |{j1_0, j2_0}, 1'b1);
      @(posedge clk); #3;
      rst0_n = 1'b0;
      #1;
      check("midrst_load", jload0, 1'b1);
      check("midrst_jclk", jclk0, 1'b0);
      check("midrst_p1", j1_0, 16'h0000);
      check("midrst_p2", j2_0, 16'h0000);
      check("midrst_fd", fd0, 1'b0);
      have_prev = 1'b0;
      exp_m = '0;
      cand_m = '0;
      repeat (5) @(posedge clk);
      @(negedge clk); rst0_n = 1'b1;
      frame_step("post_a");
      frame_step("post_b");
      frame_step("post_c");
      check("post_p1_direct", j1_0, 16'h00F0);
      check("post_p2_direct", j2_0, 16'h0F0F);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
